// File: rtl/add_serial_unit.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_unit
// Description : Bit-serial adder. Accepts an operand pair (Rd, SrcB) and
//               reconstructs SrcA = Rd + SrcB (mod 2^DATA_WIDTH) by adding
//               BITS_PER_CYCLE bits per clock, LSB slice first, then holds
//               the result with a valid/ready handshake.
//               Optional feature: define ADD_SERIAL_UNIT_OVF_EN to add the
//               Overflow output (signed overflow of the addition).
// Revision    : 1.0 - initial release
// ============================================================================
module add_serial_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1   // must divide DATA_WIDTH exactly
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] Rd,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] SrcA,
    output logic                  CarryOut
`ifdef ADD_SERIAL_UNIT_OVF_EN
    ,
    output logic                  Overflow
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_NUM_STEPS = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int c_CNT_W     = (c_NUM_STEPS > 1) ? $clog2(c_NUM_STEPS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_NUM_STEPS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [DATA_WIDTH-1:0]     r_a;          // remaining Rd bits, shifted right
    logic [DATA_WIDTH-1:0]     r_b;          // remaining SrcB bits, shifted right
    logic [DATA_WIDTH-1:0]     r_res;        // result, filled from the MSB side
    logic                      r_carry;
    logic [c_CNT_W-1:0]        r_cnt;

    logic [BITS_PER_CYCLE:0]   w_sum;        // slice sum including carry out
    logic [DATA_WIDTH-1:0]     w_res_next;
    logic                      w_last_step;

    // Slice adder: current low slices of both operands plus running carry
    assign w_sum = {1'b0, r_a[BITS_PER_CYCLE-1:0]}
                 + {1'b0, r_b[BITS_PER_CYCLE-1:0]}
                 + {{BITS_PER_CYCLE{1'b0}}, r_carry};

    assign w_last_step = (r_cnt == c_CNT_LAST);

    // A single-step configuration replaces the result outright, otherwise
    // the new slice enters at the top and older slices move down.
    generate
        if (BITS_PER_CYCLE == DATA_WIDTH) begin : g_res_full
            assign w_res_next = w_sum[BITS_PER_CYCLE-1:0];
        end else begin : g_res_shift
            assign w_res_next = {w_sum[BITS_PER_CYCLE-1:0],
                                 r_res[DATA_WIDTH-1:BITS_PER_CYCLE]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, count slices in RUN, wait in DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid)    w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_last_step) w_state_next = c_ST_DONE;
            c_ST_DONE: if (out_ready)   w_state_next = c_ST_IDLE;
            default:                    w_state_next = c_ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready is masked during reset
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: in_ready  = ~reset;
            c_ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Operand capture on acceptance, one slice per cycle while running
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= Rd;
                        r_b     <= SrcB;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                c_ST_RUN: begin
                    r_a     <= r_a >> BITS_PER_CYCLE;
                    r_b     <= r_b >> BITS_PER_CYCLE;
                    r_res   <= w_res_next;
                    r_carry <= w_sum[BITS_PER_CYCLE];
                    r_cnt   <= r_cnt + c_CNT_ONE;
                end
                default: begin
                    // DONE holds everything stable for the consumer
                end
            endcase
        end
    end

    assign SrcA     = r_res;
    assign CarryOut = r_carry;

`ifdef ADD_SERIAL_UNIT_OVF_EN
    logic r_ovf;
    logic w_msb_cin;

    // On the last step the slice MSB is the word MSB; recover its carry-in
    // from the half-sum so signed overflow is carry-in XOR carry-out.
    assign w_msb_cin = r_a[BITS_PER_CYCLE-1] ^ r_b[BITS_PER_CYCLE-1]
                     ^ w_sum[BITS_PER_CYCLE-1];

    // Capture signed overflow when the top slice is added
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if ((r_state == c_ST_RUN) && w_last_step) begin
            r_ovf <= w_msb_cin ^ w_sum[BITS_PER_CYCLE];
        end
    end

    assign Overflow = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/add_serial_unit.md
ADD_SERIAL_UNIT -- requirements
Module: add_serial_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter BITS_PER_CYCLE, default 1, giving the bits added per cycle; it must divide DATA_WIDTH exactly.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port Rd, input, DATA_WIDTH bits: difference operand.
REQ-008 The block SHALL have port SrcB, input, DATA_WIDTH bits: subtrahend operand.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-011 The block SHALL have port SrcA, output, DATA_WIDTH bits: reconstructed minuend, Rd + SrcB mod 2^DATA_WIDTH.
REQ-012 The block SHALL have port CarryOut, output, 1 bit: unsigned carry out of the MSB.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-015 Acceptance SHALL occur on a rising edge with state IDLE, in_valid=1 and reset=0; it latches Rd and SrcB, clears the carry and the counter, and enters RUN.
REQ-016 RUN SHALL add BITS_PER_CYCLE LSB-first bit slices plus the carry each cycle, shift the sum slice into the result from the MSB side, update the carry, and increment the counter.
REQ-017 After N = DATA_WIDTH/BITS_PER_CYCLE RUN cycles the FSM SHALL enter DONE, so out_valid rises exactly N edges after the acceptance edge.
REQ-018 DONE SHALL hold out_valid=1 and keep SrcA, CarryOut and Overflow stable until an edge with out_ready=1, then return to IDLE.
REQ-019 The result SHALL NOT be accepted and new operands SHALL NOT be accepted in the same cycle; in_ready SHALL rise the cycle after the result handshake.
REQ-020 The block SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-021 The carry SHALL wrap modulo 2^DATA_WIDTH; the final carry SHALL be reported on CarryOut, with no saturation.

Reset
REQ-022 While reset=1 at a clock edge, state SHALL become IDLE and out_valid, SrcA, CarryOut, Overflow and the counter SHALL become 0.
REQ-023 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after reset deasserts.
REQ-024 Reset asserted during RUN or DONE SHALL discard the operation; no out_valid pulse for it SHALL ever appear.

Configuration
REQ-025 With macro ADD_SERIAL_UNIT_OVF_EN defined, the block SHALL have an output port Overflow, 1 bit, equal to the signed overflow (MSB carry-in XOR carry-out), valid and stable with out_valid.
REQ-026 Without ADD_SERIAL_UNIT_OVF_EN, the Overflow port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Defaults, Rd=5, SrcB=3 accepted at edge E -> out_valid at edge E+32, SrcA=8, CarryOut=0.
REQ-028 Rd=0xFFFFFFFF, SrcB=1 -> SrcA=0x00000000, CarryOut=1, Overflow=0 (macro on).
REQ-029 Rd=0x7FFFFFFF, SrcB=1 -> SrcA=0x80000000, CarryOut=0, Overflow=1 (macro on).
REQ-030 out_ready held 0 for 10 cycles in DONE -> out_valid=1, SrcA unchanged and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the following cycle.
REQ-031 Reset asserted on the 10th RUN cycle -> no out_valid, all outputs 0, in_ready=1 the cycle after reset drops; the next operation (2+2) returns 4.
REQ-032 BITS_PER_CYCLE=4, Rd=0x12345678, SrcB=0x11111111 -> out_valid 8 edges after acceptance, SrcA=0x23456789.
